// File: rtl/bft_stream_tx.sv
// bft_stream_tx: transmit-side BFT leaf endpoint.
// Takes a 32-bit ap_vld/ap_ack stream from a user kernel and sends each word
// as one BFT packet to a fixed destination leaf/port. Credits track the free
// slots in the destination receive BRAM. Freespace-update packets that arrive
// on the incoming link add credits back.
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   din_user/vld_user   kernel payload and its valid strobe
//   ack_user            combinational accept strobe back to the kernel
//   din_leaf_bft2tx     incoming BFT packet (credit returns)
//   dout_leaf_tx2bft    outgoing BFT packet {valid, leaf, port, addr, payload}
//   credits             current credit count (0 .. 2^NUM_BRAM_ADDR_BITS)
//   credit_err          sticky flag, set when a return would overfill credits
module bft_stream_tx #(
  parameter int PACKET_BITS        = 49,
  parameter int PAYLOAD_BITS       = 32,
  parameter int NUM_LEAF_BITS      = 5,
  parameter int NUM_PORT_BITS      = 4,
  parameter int NUM_ADDR_BITS      = 7,
  parameter int NUM_BRAM_ADDR_BITS = 7,
  parameter int DEST_LEAF          = 0,
  parameter int DEST_PORT          = 1,
  parameter int SRC_PORT           = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [PAYLOAD_BITS-1:0]     din_user,
  input  logic                        vld_user,
  output logic                        ack_user,
  input  logic [PACKET_BITS-1:0]      din_leaf_bft2tx,
  output logic [PACKET_BITS-1:0]      dout_leaf_tx2bft,
  output logic [NUM_BRAM_ADDR_BITS:0] credits,
  output logic                        credit_err
);
  localparam int CW       = NUM_BRAM_ADDR_BITS + 1;
  localparam int PORT_LSB = PAYLOAD_BITS + NUM_ADDR_BITS;
  localparam int LEAF_LSB = PORT_LSB + NUM_PORT_BITS;
  localparam logic [CW-1:0] FULL = {1'b1, {NUM_BRAM_ADDR_BITS{1'b0}}};

  logic [PACKET_BITS-1:0]   dout_q, dout_d;
  logic [CW-1:0]            credits_q, credits_d;
  logic [NUM_ADDR_BITS-1:0] addr_q, addr_d;
  logic                     err_q, err_d;

  logic          xfer;
  logic          is_ret;
  logic [CW-1:0] ret_inc;
  logic [CW:0]   cred_sum;

  // Credit check uses only registered state, so a return can never reach
  // ack_user in the same cycle it arrives.
  assign ack_user = vld_user & (credits_q != '0) & ~reset;
  assign xfer     = vld_user & ack_user;

  // Freespace update: valid control packet (port 0) tagged with our port id.
  assign is_ret = din_leaf_bft2tx[PACKET_BITS-1]
                & (din_leaf_bft2tx[PORT_LSB +: NUM_PORT_BITS] == '0)
                & (din_leaf_bft2tx[PAYLOAD_BITS-1 -: NUM_PORT_BITS] == NUM_PORT_BITS'(SRC_PORT));
  assign ret_inc = is_ret ? din_leaf_bft2tx[CW-1:0] : '0;

  // Fields of the return packet that carry no meaning here.
  logic unused_ret_bits;
  assign unused_ret_bits = ^{din_leaf_bft2tx[LEAF_LSB +: NUM_LEAF_BITS],
                             din_leaf_bft2tx[PAYLOAD_BITS +: NUM_ADDR_BITS],
                             din_leaf_bft2tx[PAYLOAD_BITS-NUM_PORT_BITS-1:CW]};

  // One extra bit of headroom so an overfill is visible before clamping.
  // The subtraction cannot underflow: xfer implies credits_q != 0.
  assign cred_sum = {1'b0, credits_q} - {{CW{1'b0}}, xfer} + {1'b0, ret_inc};

  always_comb begin
    dout_d    = '0;
    addr_d    = addr_q;
    credits_d = cred_sum[CW-1:0];
    err_d     = err_q;
    if (xfer) begin
      dout_d = {1'b1, NUM_LEAF_BITS'(DEST_LEAF), NUM_PORT_BITS'(DEST_PORT), addr_q, din_user};
      addr_d = addr_q + 1'b1;  // natural wrap 2^NUM_ADDR_BITS-1 -> 0
    end
    if (cred_sum > {1'b0, FULL}) begin
      credits_d = FULL;
      err_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout_q    <= '0;
      credits_q <= FULL;
      addr_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      dout_q    <= dout_d;
      credits_q <= credits_d;
      addr_q    <= addr_d;
      err_q     <= err_d;
    end
  end

  assign dout_leaf_tx2bft = dout_q;
  assign credits          = credits_q;
  assign credit_err       = err_q;
endmodule
